// File: rtl/debounce_pkg.sv
// Shared state encoding and default qualification parameters for the
// switch debouncer channels.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b11,
    CHK_LO  = 2'b10
  } deb_state_t;

  localparam int unsigned DEF_STABLE_CNT = 50000;
  localparam int unsigned DEF_CNT_W      = 16;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, qualification FSM with
// counter, registered level output and one-cycle edge strobes.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  if (STABLE_CNT < 2) begin : g_bad_stable
    $error("debounce_chan: STABLE_CNT must be at least 2");
  end
  if ((longint'(1) << CNT_W) <= (longint'(STABLE_CNT) - 1)) begin : g_bad_cnt_w
    $error("debounce_chan: CNT_W too narrow for STABLE_CNT");
  end

  logic             s1, s2;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= sw;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // Counter is compared before incrementing, so it never wraps; any
  // exit from a CHK state drops it back to zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      IDLE_LO: if (s2) state_nxt = CHK_HI;
      CHK_HI: begin
        if (!s2) begin
          state_nxt = IDLE_LO;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE_HI: if (!s2) state_nxt = CHK_LO;
      CHK_LO: begin
        if (s2) begin
          state_nxt = IDLE_HI;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE_LO;
    endcase
  end

endmodule

// File: rtl/switch_debounce.sv
// Two independent debounce channels feeding the downstream AND gate's
// a/b inputs; wiring only.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_a,
  input  logic sw_b,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_chan #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw_a),
    .level (a_out),
    .rise  (a_rise),
    .fall  (a_fall)
  );

  debounce_chan #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw_b),
    .level (b_out),
    .rise  (b_rise),
    .fall  (b_fall)
  );

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: run-length reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_switch_debounce;

  localparam int ST = 4;

  logic clk, rst, sw_a, sw_b;
  logic a_out, b_out, a_rise, a_fall, b_rise, b_fall;

  int checks = 0;
  int errors = 0;

  switch_debounce #(.STABLE_CNT(ST), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_a   (sw_a),
    .sw_b   (sw_b),
    .a_out  (a_out),
    .b_out  (b_out),
    .a_rise (a_rise),
    .a_fall (a_fall),
    .b_rise (b_rise),
    .b_fall (b_fall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: synchronized input is the raw input two edges late; the
  // output flips once the synchronized value has differed from it on
  // ST+1 consecutive edges.
  logic m_pipe1 [2];
  logic m_pipe2 [2];
  logic m_out   [2];
  logic m_rise  [2];
  logic m_fall  [2];
  int   m_run   [2];
  bit   started = 1'b0;

  always @(posedge clk) begin
    logic raw [2];
    raw[0] = sw_a;
    raw[1] = sw_b;
    started = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_pipe1[c] = 1'b0; m_pipe2[c] = 1'b0; m_out[c] = 1'b0;
        m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_run[c] = 0;
      end else begin
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (m_pipe2[c] != m_out[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == ST + 1) begin
            m_out[c]  = ~m_out[c];
            m_rise[c] = m_out[c];
            m_fall[c] = ~m_out[c];
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_pipe2[c] = m_pipe1[c];
        m_pipe1[c] = raw[c];
      end
    end
  end

  int n_a_rise = 0, n_a_fall = 0, n_b_rise = 0, n_b_fall = 0;

  always @(negedge clk) begin
    if (started) begin
      logic [5:0] got, exp;
      got = {a_out, b_out, a_rise, a_fall, b_rise, b_fall};
      exp = {m_out[0], m_out[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, got, exp);
      end
      if (a_rise === 1'b1) n_a_rise++;
      if (a_fall === 1'b1) n_a_fall++;
      if (b_rise === 1'b1) n_b_rise++;
      if (b_fall === 1'b1) n_b_fall++;
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Drive at a negedge; the following posedge samples these values.
  task automatic step(input logic a, input logic b, input logic r);
    @(negedge clk);
    sw_a = a;
    sw_b = b;
    rst  = r;
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    hold(1'b0, 1'b0, 3);
  endtask

  int base_r, base_f;

  initial begin
    sw_a = 1'b0; sw_b = 1'b0; rst = 1'b1;

    // Reset with both switches high, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    lit("rst_a_out", int'(a_out), 0);
    lit("rst_b_out", int'(b_out), 0);
    lit("rst_strobes", int'({a_rise, a_fall, b_rise, b_fall}), 0);
    hold(1'b1, 1'b1, 6);                  // outputs now reflect edge 6
    lit("rst_a_edge6", int'(a_out), 0);
    step(1'b1, 1'b1, 1'b0);               // edge 7 done
    lit("rst_a_edge7", int'(a_out), 1);
    lit("rst_b_edge7", int'(b_out), 1);
    lit("rst_a_rise", int'(a_rise), 1);
    step(1'b1, 1'b1, 1'b0);
    lit("rst_rise_clear", int'(a_rise | b_rise), 0);
    lit("rst_rise_count", n_a_rise + n_b_rise, 2);

    // Bounce rejection
    do_reset();
    base_r = n_a_rise;
    hold(1'b1, 1'b0, 2); hold(1'b0, 1'b0, 1);
    hold(1'b1, 1'b0, 1); hold(1'b0, 1'b0, 12);
    lit("bounce_a_out", int'(a_out), 0);
    lit("bounce_no_strobe", n_a_rise - base_r, 0);

    // Clean press and release
    do_reset();
    base_f = n_a_fall;
    hold(1'b1, 1'b0, 7);
    lit("press_edge6", int'(a_out), 0);
    hold(1'b1, 1'b0, 1);
    lit("press_edge7", int'(a_out), 1);
    hold(1'b1, 1'b0, 2);
    hold(1'b0, 1'b0, 7);
    lit("release_edge6", int'(a_out), 1);
    hold(1'b0, 1'b0, 1);
    lit("release_edge7", int'(a_out), 0);
    hold(1'b0, 1'b0, 4);
    lit("release_fall_once", n_a_fall - base_f, 1);

    // Threshold boundary: raw pulse of ST cycles rejected, ST+1 accepted
    do_reset();
    hold(1'b0, 1'b1, ST); hold(1'b0, 1'b0, 12);
    lit("thresh_short", int'(b_out), 0);
    hold(1'b0, 1'b1, ST + 1); hold(1'b0, 1'b0, 3);
    lit("thresh_long", int'(b_out), 1);
    hold(1'b0, 1'b0, 12);

    // Reset mid-qualification
    do_reset();
    hold(1'b1, 1'b0, 4);
    step(1'b1, 1'b0, 1'b1);               // rst on edge 5
    step(1'b1, 1'b0, 1'b0);
    lit("midrst_a_out", int'(a_out), 0);
    hold(1'b1, 1'b0, 6);
    lit("midrst_edge6", int'(a_out), 0);
    hold(1'b1, 1'b0, 1);
    lit("midrst_edge7", int'(a_out), 1);

    // Independence: A held high while B toggles every cycle
    do_reset();
    base_r = n_b_rise;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, logic'(i % 2), 1'b0);
      if (i == 7) lit("indep_a_edge7", int'(a_out), 1);
    end
    lit("indep_b_out", int'(b_out), 0);
    lit("indep_b_no_rise", n_b_rise - base_r, 0);

    // Random traffic with run lengths straddling the threshold
    begin
      logic ta, tb;
      ta = 1'b0; tb = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(5) == 0) ta = ~ta;
        if ($urandom_range(5) == 0) tb = ~tb;
        step(ta, tb, logic'($urandom_range(199) == 0));
      end
    end
    hold(1'b0, 1'b0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
